// File: rtl/daytime_code_gen.sv
// daytime_code_gen: hour-of-day counter with one-hot day-period code and change strobe
module daytime_code_gen #(
    parameter int TICKS_PER_HOUR = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       hold,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    output logic [4:0] hour,
    output logic [3:0] tcode,
    output logic       tcode_chg,
    output logic       set_err
);
    localparam int CW = $clog2(TICKS_PER_HOUR);
    localparam logic [CW-1:0] LAST = CW'(TICKS_PER_HOUR - 1);

    logic [CW-1:0] sub_cnt, sub_nx;
    logic [4:0] hour_nx;
    logic [3:0] tcode_nx;
    logic set_ok, adv, wrap;

    // next-state hour/sub-count with priority set_en > hold > tick; tcode decoded from next hour
    always_comb begin
        set_ok   = set_en && set_hour <= 5'd23;
        adv      = !set_en && !hold && tick;
        wrap     = adv && sub_cnt == LAST;
        hour_nx  = set_ok ? set_hour : wrap ? (hour == 5'd23 ? 5'd0 : hour + 5'd1) : hour;
        sub_nx   = set_ok ? '0 : adv ? (wrap ? '0 : sub_cnt + CW'(1)) : sub_cnt;
        tcode_nx = hour_nx < 5'd6  ? 4'b0000 :
                   hour_nx < 5'd12 ? 4'b0001 :
                   hour_nx < 5'd17 ? 4'b0010 :
                   hour_nx < 5'd20 ? 4'b0100 : 4'b1000;
    end

    // state and output registers; change strobe compares new code against the one on the output
    always_ff @(posedge clk) begin
        if (rst) begin
            sub_cnt   <= '0;
            hour      <= '0;
            tcode     <= '0;
            tcode_chg <= 1'b0;
            set_err   <= 1'b0;
        end else begin
            sub_cnt   <= sub_nx;
            hour      <= hour_nx;
            tcode     <= tcode_nx;
            tcode_chg <= tcode_nx != tcode;
            set_err   <= set_en && set_hour > 5'd23;
        end
    end
endmodule

// File: tb/tb_daytime_code_gen.sv
// tb_daytime_code_gen: directed scenarios plus random traffic against a behavioural clock model
module tb_daytime_code_gen;
    localparam int TPH = 4;

    logic clk = 1'b0;
    logic rst, tick, hold, set_en;
    logic [4:0] set_hour, hour;
    logic [3:0] tcode;
    logic tcode_chg, set_err;

    int vectors = 0;
    int miss = 0;

    int m_hour = 0, m_sub = 0, m_tc = 0, m_chg = 0, m_err = 0;

    daytime_code_gen #(.TICKS_PER_HOUR(TPH)) dut (
        .clk(clk), .rst(rst), .tick(tick), .hold(hold), .set_en(set_en),
        .set_hour(set_hour), .hour(hour), .tcode(tcode),
        .tcode_chg(tcode_chg), .set_err(set_err)
    );

    always #5 clk = ~clk;

    function automatic int period(int h);
        if (h < 6) return 0;
        if (h < 12) return 1;
        if (h < 17) return 2;
        if (h < 20) return 4;
        return 8;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input logic t, input logic ho, input logic se, input logic [4:0] sh, input logic r);
        int nt;
        @(negedge clk);
        tick = t; hold = ho; set_en = se; set_hour = sh; rst = r;
        @(posedge clk);
        if (r) begin
            m_hour = 0; m_sub = 0; m_tc = 0; m_chg = 0; m_err = 0;
        end else begin
            m_err = (se && sh > 23) ? 1 : 0;
            if (se && sh <= 23) begin
                m_hour = sh; m_sub = 0;
            end else if (!se && !ho && t) begin
                m_sub = m_sub + 1;
                if (m_sub == TPH) begin
                    m_sub = 0;
                    m_hour = (m_hour + 1) % 24;
                end
            end
            nt = period(m_hour);
            m_chg = (nt != m_tc) ? 1 : 0;
            m_tc = nt;
        end
        #1;
        chk("hour", 8'(hour), 8'(m_hour));
        chk("tcode", 8'(tcode), 8'(m_tc));
        chk("tcode_chg", 8'(tcode_chg), 8'(m_chg));
        chk("set_err", 8'(set_err), 8'(m_err));
    endtask

    initial begin
        int chg_cnt;
        tick = 0; hold = 0; set_en = 0; set_hour = 0; rst = 1;
        step(0, 0, 0, 0, 1);
        step(1, 1, 1, 5'd31, 1);
        chk("reset_hour", 8'(hour), 8'd0);
        step(0, 0, 0, 0, 0);
        chk("reset_exit_chg", 8'(tcode_chg), 8'd0);
        chg_cnt = 0;
        for (int i = 0; i < 24; i++) begin
            step(1, 0, 0, 0, 0);
            chg_cnt += tcode_chg;
        end
        chk("s30_hour", 8'(hour), 8'd6);
        chk("s30_tcode", 8'(tcode), 8'b0001);
        chk("s30_chg_last", 8'(tcode_chg), 8'd1);
        chk("s30_chg_count", 8'(chg_cnt), 8'd1);
        step(0, 0, 1, 5'd23, 0);
        chk("s31_tcode_set", 8'(tcode), 8'b1000);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        chk("s31_hour", 8'(hour), 8'd0);
        chk("s31_tcode", 8'(tcode), 8'b0000);
        step(0, 0, 1, 5'd10, 0);
        step(0, 0, 1, 5'd25, 0);
        chk("s32_hour", 8'(hour), 8'd10);
        chk("s32_err", 8'(set_err), 8'd1);
        step(0, 0, 0, 0, 0);
        chk("s32_err_clear", 8'(set_err), 8'd0);
        step(0, 0, 1, 5'd16, 0);
        for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0);
        chk("s33_hold_hour", 8'(hour), 8'd16);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        chk("s33_hour", 8'(hour), 8'd17);
        chk("s33_tcode", 8'(tcode), 8'b0100);
        step(0, 0, 1, 5'd5, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 5'd12, 0);
        chk("s34_hour", 8'(hour), 8'd12);
        chk("s34_tcode", 8'(tcode), 8'b0010);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
        chk("s34_no_early_adv", 8'(hour), 8'd12);
        step(1, 0, 0, 0, 0);
        chk("s34_adv", 8'(hour), 8'd13);
        step(0, 0, 1, 5'd19, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        chk("s35_hour", 8'(hour), 8'd0);
        chk("s35_chg", 8'(tcode_chg), 8'd0);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0);
        chk("s35_resume", 8'(hour), 8'd1);
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 1)), $urandom_range(0, 4) == 0, $urandom_range(0, 15) == 0,
                 5'($urandom_range(0, 31)), $urandom_range(0, 60) == 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end
endmodule

// File: doc/daytime_code_gen.md
DAYTIME_CODE_GEN -- requirements
Module: daytime_code_gen

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter TICKS_PER_HOUR, default 60: the number of accepted tick pulses that make up one hour (legal range 2..255).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port tick, input, 1 bit: time-base strobe, sampled once per clk edge.
REQ-006 The block SHALL have port hold, input, 1 bit: when 1, tick is ignored and time freezes.
REQ-007 The block SHALL have port set_en, input, 1 bit: one-cycle request to load set_hour.
REQ-008 The block SHALL have port set_hour, input, 5 bits: hour to load, legal 0..23.
REQ-009 The block SHALL have port hour, output, 5 bits: current hour, 0..23, registered.
REQ-010 The block SHALL have port tcode, output, 4 bits: one-hot day-period code, registered, feeding LightingSystem.tcode.
REQ-011 The block SHALL have port tcode_chg, output, 1 bit: single-cycle pulse marking a tcode change.
REQ-012 The block SHALL have port set_err, output, 1 bit: single-cycle pulse marking a rejected set request.

Function
REQ-013 The block SHALL hold an internal sub-hour counter sub_cnt of width ceil(log2(TICKS_PER_HOUR)) with range 0..TICKS_PER_HOUR-1.
REQ-014 When tick=1, hold=0 and set_en=0, sub_cnt SHALL increment; on the tick where sub_cnt = TICKS_PER_HOUR-1, sub_cnt SHALL wrap to 0 and hour SHALL advance.
REQ-015 Hour advance SHALL be hour+1, with wrap from 23 to 0; hour SHALL never hold a value above 23.
REQ-016 tcode SHALL be decoded from the next-state hour and registered, so that tcode changes on the same clk edge as hour; there SHALL be no extra latency.
REQ-017 The tcode mapping SHALL be: hours 0-5 -> 4'b0000 (off); hours 6-11 -> 4'b0001; hours 12-16 -> 4'b0010; hours 17-19 -> 4'b0100; hours 20-23 -> 4'b1000.
REQ-018 tcode SHALL always be either 4'b0000 or exactly one-hot.
REQ-019 tcode_chg SHALL be 1 in exactly the cycle in which the new tcode value first appears on the output.
REQ-020 tcode_chg SHALL be 0 when the hour changes but tcode does not.
REQ-021 When set_en=1 and set_hour<=23, the block SHALL load hour=set_hour, clear sub_cnt to 0 and update tcode on the same edge; tcode_chg SHALL pulse if tcode differs.
REQ-022 When set_en=1 and set_hour>23, the block SHALL leave hour, sub_cnt and tcode unchanged and pulse set_err for one cycle.
REQ-023 Priority SHALL be rst > set_en > hold > tick; a tick coincident with set_en SHALL be discarded.
REQ-024 set_en SHALL be honoured while hold=1.
REQ-025 While hold=1, sub_cnt and hour SHALL be frozen and tcode_chg SHALL stay 0, except as caused by set_en.

Reset
REQ-026 When rst=1 at a clk edge, the block SHALL set hour=0, sub_cnt=0, tcode=4'b0000, tcode_chg=0 and set_err=0, regardless of the other inputs.
REQ-027 Reset asserted mid-hour SHALL discard the partial sub_cnt.
REQ-028 On the first edge after rst deasserts, the block SHALL resume normal operation.
REQ-029 tcode_chg SHALL NOT pulse on reset entry or reset exit.

Verification (TICKS_PER_HOUR=4)
REQ-030 Scenario: reset, then 24 ticks -> hour reaches 6 and tcode becomes 4'b0001 on the 24th tick edge, with a single tcode_chg pulse on that edge.
REQ-031 Scenario: set hour=23, then 4 ticks -> hour=0, tcode transitions 4'b1000 -> 4'b0000, and tcode_chg pulses once.
REQ-032 Scenario: set_hour=25 at hour=10 -> hour stays 10, tcode stays 4'b0001, set_err pulses for 1 cycle, and tcode_chg=0.
REQ-033 Scenario: set hour=16, then hold=1 with 10 ticks, then hold=0 and 4 ticks -> hour stays 16 during hold, then becomes 17, tcode=4'b0100.
REQ-034 Scenario: set_en (set_hour=12) and tick in the same cycle at sub_cnt=3 -> hour=12, sub_cnt=0, tcode=4'b0010, and the tick is discarded.
REQ-035 Scenario: rst at hour=19, sub_cnt=2 -> next cycle hour=0, tcode=4'b0000, tcode_chg=0; then 4 ticks give hour=1.
